dense_forward_param: RTL and testbench



---
 rtl/dense_forward_param_pkg.sv | 26 ++
 rtl/dense_forward_param_inner_lanes.sv | 54 +++++
 rtl/dense_forward_param.sv | 186 ++++++++++++++++++
 tb/tb_dense_forward_param.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_forward_param_pkg.sv
// Shared defaults, FSM state codes and width helper for the dense forward-pass block.
package dense_forward_param_pkg;

    localparam int DEF_IN_DIM    = 24;
    localparam int DEF_OUT_DIM   = 200;
    localparam int DEF_LANES     = 8;
    localparam int DEF_X_W       = 16;
    localparam int DEF_W_W       = 16;
    localparam int DEF_Q_W       = 16;
    localparam int DEF_FRAC      = 8;
    localparam int DEF_INNER_LAT = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ceil(log2(v)), never below 1 so it is always usable as a vector width
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dense_forward_param_inner_lanes.sv
// LANES signed multipliers followed by a full-precision adder tree.
// Products are registered, then INNER_LAT-1 further stages delay the sum.
module dense_inner_lanes
    import dense_forward_param_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int X_W       = DEF_X_W,
    parameter int W_W       = DEF_W_W,
    parameter int INNER_LAT = DEF_INNER_LAT,
    parameter int S_W       = X_W + W_W + clog2_min1(LANES)
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LANES*X_W-1:0]        x,
    input  logic [LANES*W_W-1:0]        w,
    output logic signed [S_W-1:0]       sum
);
    localparam int P_W = X_W + W_W;

    logic signed [P_W-1:0] prod_q [LANES];
    logic signed [S_W-1:0] sum_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) prod_q[l] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++)
                prod_q[l] <= P_W'($signed(x[l*X_W +: X_W])) * P_W'($signed(w[l*W_W +: W_W]));
        end
    end

    always_comb begin
        sum_c = '0;
        for (int l = 0; l < LANES; l++) sum_c = sum_c + S_W'(prod_q[l]);
    end

    if (INNER_LAT == 1) begin : g_lat1
        assign sum = sum_c;
    end else begin : g_latn
        logic signed [S_W-1:0] stage [INNER_LAT-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < INNER_LAT-1; i++) stage[i] <= '0;
            end else begin
                stage[0] <= sum_c;
                for (int i = 1; i < INNER_LAT-1; i++) stage[i] <= stage[i-1];
            end
        end

        assign sum = stage[INNER_LAT-2];
    end

endmodule

// File: rtl/dense_forward_param.sv
// Dense-layer forward pass: q[r] = sat(bias[r] + sum_k W[r][k]*d[k]), LANES MACs per cycle.
// Weights stream from an external RAM with one cycle of read latency.
module dense_forward_param
    import dense_forward_param_pkg::*;
#(
    parameter int IN_DIM    = DEF_IN_DIM,
    parameter int OUT_DIM   = DEF_OUT_DIM,
    parameter int LANES     = DEF_LANES,
    parameter int X_W       = DEF_X_W,
    parameter int W_W       = DEF_W_W,
    parameter int Q_W       = DEF_Q_W,
    parameter int FRAC      = DEF_FRAC,
    parameter int INNER_LAT = DEF_INNER_LAT
)(
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          run,
    input  logic                                          bias_en,
    input  logic                                          relu_en,
    input  logic [IN_DIM*X_W-1:0]                         d,
    input  logic [OUT_DIM*Q_W-1:0]                        bias,
    output logic [clog2_min1(OUT_DIM*(IN_DIM/LANES))-1:0] raddr,
    input  logic [LANES*W_W-1:0]                          rdata,
    output logic                                          valid,
    output logic [OUT_DIM*Q_W-1:0]                        q
);
    // state    | meaning
    // IDLE     | waiting for run; flags latched on exit
    // RUN      | issuing one weight word per cycle, raddr = n
    // DRAIN    | all words issued, waiting for the last row write-back
    // DONE     | results complete, valid follows run

    localparam int CHUNKS  = IN_DIM / LANES;
    localparam int N_ISSUE = OUT_DIM * CHUNKS;
    localparam int RA_W    = clog2_min1(N_ISSUE);
    localparam int C_W     = clog2_min1(CHUNKS);
    localparam int ROW_W   = clog2_min1(OUT_DIM);
    localparam int S_W     = X_W + W_W + clog2_min1(LANES);
    localparam int ACC_W   = X_W + W_W + $clog2(IN_DIM) + 1;
    localparam int TAG_LAT = INNER_LAT + 1;
    localparam int L       = TAG_LAT - 1;

    localparam logic signed [ACC_W-1:0] Q_MAX = {{(ACC_W-Q_W+1){1'b0}}, {(Q_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

    logic [1:0]             state;
    logic [RA_W-1:0]        n;
    logic [C_W-1:0]         c;
    logic [ROW_W-1:0]       r;
    logic                   bias_en_q;
    logic                   relu_en_q;
    logic [LANES*X_W-1:0]   d_slice_q;

    logic                   tag_v     [TAG_LAT];
    logic                   tag_first [TAG_LAT];
    logic                   tag_last  [TAG_LAT];
    logic [ROW_W-1:0]       tag_row   [TAG_LAT];

    logic signed [S_W-1:0]   sum;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] y;
    logic [Q_W-1:0]          qv;
    logic                    wr;
    logic                    last_row_done;

    // Write-back is suppressed in the abort cycle itself so no in-flight row lands.
    assign wr            = tag_v[L] & run;
    assign last_row_done = wr & tag_last[L] & (tag_row[L] == ROW_W'(OUT_DIM-1));
    assign raddr         = n;
    assign valid         = (state == ST_DONE) & run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            n         <= '0;
            c         <= '0;
            r         <= '0;
            bias_en_q <= 1'b0;
            relu_en_q <= 1'b0;
        end else if (!run) begin
            state <= ST_IDLE;
            n     <= '0;
            c     <= '0;
            r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state     <= ST_RUN;
                    n         <= '0;
                    c         <= '0;
                    r         <= '0;
                    bias_en_q <= bias_en;
                    relu_en_q <= relu_en;
                end
                ST_RUN: begin
                    if (n == RA_W'(N_ISSUE-1)) begin
                        state <= ST_DRAIN;
                        n     <= '0;
                        c     <= '0;
                        r     <= '0;
                    end else begin
                        n <= n + RA_W'(1);
                        if (c == C_W'(CHUNKS-1)) begin
                            c <= '0;
                            r <= r + ROW_W'(1);
                        end else begin
                            c <= c + C_W'(1);
                        end
                    end
                end
                ST_DRAIN: if (last_row_done) state <= ST_DONE;
                default: state <= state;
            endcase
        end
    end

    // Activation slice and tag travel alongside the weight word through the lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_slice_q <= '0;
            for (int i = 0; i < TAG_LAT; i++) begin
                tag_v[i]     <= 1'b0;
                tag_first[i] <= 1'b0;
                tag_last[i]  <= 1'b0;
                tag_row[i]   <= '0;
            end
        end else begin
            d_slice_q    <= d[c*LANES*X_W +: LANES*X_W];
            tag_v[0]     <= run & (state == ST_RUN);
            tag_first[0] <= (c == '0);
            tag_last[0]  <= (c == C_W'(CHUNKS-1));
            tag_row[0]   <= r;
            for (int i = 1; i < TAG_LAT; i++) begin
                tag_v[i]     <= run & tag_v[i-1];
                tag_first[i] <= tag_first[i-1];
                tag_last[i]  <= tag_last[i-1];
                tag_row[i]   <= tag_row[i-1];
            end
        end
    end

    dense_inner_lanes #(
        .LANES     (LANES),
        .X_W       (X_W),
        .W_W       (W_W),
        .INNER_LAT (INNER_LAT),
        .S_W       (S_W)
    ) u_inner (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (d_slice_q),
        .w     (rdata),
        .sum   (sum)
    );

    always_comb begin
        acc_base = '0;
        if (!tag_first[L])
            acc_base = acc;
        else if (bias_en_q)
            acc_base = ACC_W'($signed(bias[tag_row[L]*Q_W +: Q_W])) <<< FRAC;
        acc_next = acc_base + ACC_W'(sum);
        y        = acc_next >>> FRAC;
        if (y > Q_MAX)
            qv = Q_MAX[Q_W-1:0];
        else if (y < Q_MIN)
            qv = Q_MIN[Q_W-1:0];
        else
            qv = y[Q_W-1:0];
        if (relu_en_q && y[ACC_W-1])
            qv = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            q   <= '0;
        end else if (wr) begin
            acc <= acc_next;
            if (tag_last[L]) q[tag_row[L]*Q_W +: Q_W] <= qv;
        end
    end

endmodule

// File: tb/tb_dense_forward_param.sv
// Bench for dense_forward_param: a small FRAC=0 instance and a default-size instance,
// both fed from behavioural weight RAMs and checked against an integer reference model.
module tb_dense_forward_param;

    localparam int LAT = 2;
    localparam int IS = 8,  OS = 4,   LS = 4, CS = 2, NIS = 8;
    localparam int IL = 24, OL = 200, LL = 8, CL = 3, NIL = 600;
    localparam int FRAC_L = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              run_s = 1'b0, ben_s = 1'b0, ren_s = 1'b0;
    logic [IS*16-1:0]  d_s = '0;
    logic [OS*16-1:0]  bias_s = '0;
    logic [2:0]        raddr_s;
    logic [LS*16-1:0]  rdata_s = '0;
    logic              valid_s;
    logic [OS*16-1:0]  q_s;

    logic              run_l = 1'b0, ben_l = 1'b0, ren_l = 1'b0;
    logic [IL*16-1:0]  d_l = '0;
    logic [OL*16-1:0]  bias_l = '0;
    logic [9:0]        raddr_l;
    logic [LL*16-1:0]  rdata_l = '0;
    logic              valid_l;
    logic [OL*16-1:0]  q_l;

    logic [LS*16-1:0] mem_s [NIS];
    logic [LL*16-1:0] mem_l [NIL];

    always @(posedge clk) rdata_s <= mem_s[raddr_s];
    always @(posedge clk) rdata_l <= mem_l[raddr_l];

    dense_forward_param #(
        .IN_DIM(IS), .OUT_DIM(OS), .LANES(LS), .X_W(16), .W_W(16), .Q_W(16),
        .FRAC(0), .INNER_LAT(LAT)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .run(run_s), .bias_en(ben_s), .relu_en(ren_s),
        .d(d_s), .bias(bias_s), .raddr(raddr_s), .rdata(rdata_s), .valid(valid_s), .q(q_s)
    );

    dense_forward_param #(
        .IN_DIM(IL), .OUT_DIM(OL), .LANES(LL), .X_W(16), .W_W(16), .Q_W(16),
        .FRAC(FRAC_L), .INNER_LAT(LAT)
    ) dut_l (
        .clk(clk), .rst_n(rst_n), .run(run_l), .bias_en(ben_l), .relu_en(ren_l),
        .d(d_l), .bias(bias_l), .raddr(raddr_l), .rdata(rdata_l), .valid(valid_l), .q(q_l)
    );

    int     ws [OS][IS];
    int     ds [IS];
    int     bs [OS];
    longint qexp_s [OS];
    int     wl [OL][IL];
    int     dl [IL];
    int     bl [OL];
    longint qexp_l [OL];

    int sums_br [OS]  = '{5, -3, 0, 7};
    int bias_br [OS]  = '{1, 1, -1, -10};
    int q_relu [OS]   = '{6, 0, 0, 0};
    int q_norelu [OS] = '{6, -2, -1, -3};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd16(input bit small_mag);
        logic [15:0] t;
        if (small_mag) return int'($urandom_range(400)) - 200;
        t = 16'($urandom);
        return int'($signed(t));
    endfunction

    function automatic longint sat_relu(input longint acc, input int frac, input bit ren);
        longint y;
        y = acc >>> frac;
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
        if (ren && y < 0) y = 0;
        return y;
    endfunction

    function automatic longint ref_s(input int r, input bit ben, input bit ren);
        longint acc;
        acc = ben ? longint'(bs[r]) : 64'sd0;
        for (int k = 0; k < IS; k++) acc += longint'(ds[k]) * longint'(ws[r][k]);
        return sat_relu(acc, 0, ren);
    endfunction

    function automatic longint ref_l(input int r, input bit ben, input bit ren);
        longint acc;
        acc = ben ? longint'(bl[r]) * (64'sd1 << FRAC_L) : 64'sd0;
        for (int k = 0; k < IL; k++) acc += longint'(dl[k]) * longint'(wl[r][k]);
        return sat_relu(acc, FRAC_L, ren);
    endfunction

    function automatic longint qel(input bit big, input int r);
        logic signed [15:0] e;
        e = big ? q_l[r*16 +: 16] : q_s[r*16 +: 16];
        return longint'(e);
    endfunction

    task automatic load_s();
        for (int k = 0; k < IS; k++) d_s[k*16 +: 16] = 16'(ds[k]);
        for (int r = 0; r < OS; r++) bias_s[r*16 +: 16] = 16'(bs[r]);
        for (int r = 0; r < OS; r++)
            for (int c = 0; c < CS; c++)
                for (int l = 0; l < LS; l++) mem_s[r*CS+c][l*16 +: 16] = 16'(ws[r][c*LS+l]);
    endtask

    task automatic load_l();
        for (int k = 0; k < IL; k++) d_l[k*16 +: 16] = 16'(dl[k]);
        for (int r = 0; r < OL; r++) bias_l[r*16 +: 16] = 16'(bl[r]);
        for (int r = 0; r < OL; r++)
            for (int c = 0; c < CL; c++)
                for (int l = 0; l < LL; l++) mem_l[r*CL+c][l*16 +: 16] = 16'(wl[r][c*LL+l]);
    endtask

    task automatic rand_s(input bit small_mag);
        for (int k = 0; k < IS; k++) ds[k] = rnd16(small_mag);
        for (int r = 0; r < OS; r++) begin
            bs[r] = rnd16(small_mag);
            for (int k = 0; k < IS; k++) ws[r][k] = rnd16(small_mag);
        end
    endtask

    task automatic rand_l();
        for (int k = 0; k < IL; k++) dl[k] = rnd16(1'b0);
        for (int r = 0; r < OL; r++) begin
            bl[r] = rnd16(1'b0);
            for (int k = 0; k < IL; k++) wl[r][k] = rnd16(1'b0);
        end
    endtask

    // Leaves the bench 1 time unit after edge T0.
    task automatic start(input bit big);
        @(posedge clk); #1;
        if (big) run_l = 1'b1; else run_s = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic stop(input bit big, input string tag);
        if (big) run_l = 1'b0; else run_s = 1'b0;
        #1;
        chk({tag, " valid_drop"}, big ? valid_l : valid_s, 0);
        @(posedge clk); #1;
    endtask

    // Called 1 time unit after T0; checks the address sequence and valid latency.
    task automatic wait_done(input bit big, input string tag);
        int ni, lat_exp, fv;
        ni      = big ? NIL : NIS;
        lat_exp = ni + LAT + 1;
        fv      = -1;
        for (int i = 0; i <= lat_exp + 5 && fv < 0; i++) begin
            if (big ? valid_l : valid_s) fv = i;
            else begin
                chk({tag, " raddr"}, big ? raddr_l : raddr_s, (i < ni) ? i : 0);
                @(posedge clk); #1;
            end
        end
        chk({tag, " latency"}, fv, lat_exp);
    endtask

    task automatic pass_s(input string tag, input bit ben, input bit ren, input bit use_model);
        ben_s = ben;
        ren_s = ren;
        load_s();
        start(1'b0);
        wait_done(1'b0, tag);
        for (int r = 0; r < OS; r++) begin
            if (use_model) qexp_s[r] = ref_s(r, ben, ren);
            chk({tag, " q"}, qel(1'b0, r), qexp_s[r]);
        end
        stop(1'b0, tag);
    endtask

    task automatic pass_l(input string tag, input bit ben, input bit ren);
        int bad;
        ben_l = ben;
        ren_l = ren;
        load_l();
        start(1'b1);
        wait_done(1'b1, tag);
        bad = 0;
        for (int r = 0; r < OL; r++) begin
            qexp_l[r] = ref_l(r, ben, ren);
            chk({tag, " q"}, qel(1'b1, r), qexp_l[r]);
        end
        stop(1'b1, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NIS; i++) mem_s[i] = '0;
        for (int i = 0; i < NIL; i++) mem_l[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset valid_s", valid_s, 0);
        chk("reset raddr_s", raddr_s, 0);
        chk("reset valid_l", valid_l, 0);
        chk("reset raddr_l", raddr_l, 0);
        for (int r = 0; r < OS; r++) chk("reset q_s", qel(1'b0, r), 0);

        // identity-like rows: row r picks d[r] and d[r+4]
        for (int k = 0; k < IS; k++) ds[k] = k + 1;
        for (int r = 0; r < OS; r++) begin
            bs[r] = rnd16(1'b1);
            for (int k = 0; k < IS; k++) ws[r][k] = (k == r || k == r + 4) ? 1 : 0;
        end
        pass_s("basic", 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < IS; k++) ds[k] = (k == 0) ? 1 : 0;
        for (int r = 0; r < OS; r++) begin
            bs[r] = bias_br[r];
            for (int k = 0; k < IS; k++) ws[r][k] = (k == 0) ? sums_br[r] : rnd16(1'b1);
        end
        for (int r = 0; r < OS; r++) qexp_s[r] = q_relu[r];
        pass_s("bias_relu", 1'b1, 1'b1, 1'b0);
        for (int r = 0; r < OS; r++) qexp_s[r] = q_norelu[r];
        pass_s("bias_norelu", 1'b1, 1'b0, 1'b0);

        for (int p = 0; p < 6; p++) begin
            rand_s(p[0]);
            pass_s("rand_s", 1'($urandom), 1'($urandom), 1'b1);
        end

        // abort: run drops after T0+5, low for two edges, then a new pass
        rand_s(1'b1);
        ben_s = 1'b1;
        ren_s = 1'b0;
        load_s();
        start(1'b0);
        repeat (5) @(posedge clk);
        #1;
        run_s = 1'b0;
        #1;
        chk("abort valid", valid_s, 0);
        qexp_s[0] = ref_s(0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("abort valid_low", valid_s, 0);
            chk("abort raddr", raddr_s, 0);
        end
        for (int r = 0; r < OS; r++) chk("abort q_kept", qel(1'b0, r), qexp_s[r]);
        rand_s(1'b1);
        load_s();
        run_s = 1'b1;
        @(posedge clk); #1;
        wait_done(1'b0, "restart");
        for (int r = 0; r < OS; r++) begin
            qexp_s[r] = ref_s(r, 1'b1, 1'b0);
            chk("restart q", qel(1'b0, r), qexp_s[r]);
        end
        stop(1'b0, "restart");

        // asynchronous reset in the middle of a pass
        rand_s(1'b1);
        load_s();
        start(1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        run_s = 1'b0;
        #1;
        chk("rst_mid valid", valid_s, 0);
        chk("rst_mid raddr", raddr_s, 0);
        for (int r = 0; r < OS; r++) chk("rst_mid q", qel(1'b0, r), 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel raddr", raddr_s, 0);
        chk("rst_rel valid", valid_s, 0);
        rand_s(1'b0);
        pass_s("after_rst", 1'b1, 1'b1, 1'b1);

        // saturation on the default-size instance
        for (int k = 0; k < IL; k++) dl[k] = 32767;
        for (int r = 0; r < OL; r++) begin
            bl[r] = 0;
            for (int k = 0; k < IL; k++) wl[r][k] = 32767;
        end
        pass_l("sat_pos", 1'b0, 1'b0);
        chk("sat_pos const", qel(1'b1, 0), 32767);
        for (int r = 0; r < OL; r++)
            for (int k = 0; k < IL; k++) wl[r][k] = -32767;
        pass_l("sat_neg", 1'b0, 1'b0);
        chk("sat_neg const", qel(1'b1, OL-1), -32768);

        for (int p = 0; p < 20; p++) begin
            rand_l();
            pass_l("rand_l", 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
